regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single synchronous write port of the 32x32 MIPS register file among NREQ writeback requesters (ALU, load unit, multiply/divide unit, …) using round-robin arbitration and a valid/ready handshake per requester. It also keeps a 32-bit pending-write scoreboard so that issue logic can stall on registers with an outstanding producer. It sits between the writeback sources and the register file's WriteData/WriteRegister/RegWrite inputs, and drives them from registers.

## Interface
- NREQ, 4, number of requesters (2..8)
- Clk  in  1  clock; all state updates on the positive edge
- Reset  in  1  asynchronous, active-high reset
- ReqValid  in  NREQ  requester i has a write pending
- ReqAddr  in  5*NREQ  requester i destination in bits [5i+4:5i]
- ReqData  in  32*NREQ  requester i data in bits [32i+31:32i]
- ReqReady  out  NREQ  one-hot grant; a transfer occurs on a rising edge with ReqValid[i] & ReqReady[i]
- Reserve  in  1  marks ReserveAddr as having an outstanding producer
- ReserveAddr  in  5  register being reserved
- RegWrite  out  1  to the register file write enable
- WriteRegister  out  5  to the register file write address
- WriteData  out  32  to the register file write data
- Pending  out  32  scoreboard; bit r set while a write to r is outstanding

## Operation
- Round-robin pointer Ptr (log2 NREQ bits). The winner is the first i with ReqValid[i], searching Ptr, Ptr+1, … modulo NREQ.
- ReqReady is combinational from ReqValid and Ptr. At most one bit is high, and only for a valid requester. It is all-zero when no requester is valid, and all-zero while Reset is high.
- On a transfer from winner g, Ptr becomes (g+1) mod NREQ. With no transfer, Ptr holds.
- Output stage, updated every edge:
  - After a transfer with address a≠0: RegWrite=1, WriteRegister=a, WriteData=data.
  - After a transfer with address 0: the transfer is accepted, RegWrite=0, and WriteRegister/WriteData hold.
  - With no transfer: RegWrite=0, and WriteRegister/WriteData hold their last values.
- Requester obligation: hold ReqValid, ReqAddr and ReqData stable until ReqReady. The block accepts one write per cycle with no bubbles.
- Scoreboard:
  - Pending[r] sets on an edge with Reserve=1 and ReserveAddr=r≠0.
  - Pending[r] clears on an edge with a transfer to address r.
  - If a set and a clear hit the same r on the same edge, the set wins.
  - Pending[0] is always 0. Reserve to address 0 is ignored.
- Outputs are never driven by the register file itself. Same-address collisions between requesters are serialised in grant order. Last accepted wins in the file.

## Timing
- Reset values: Ptr=0, RegWrite=0, WriteRegister=0, WriteData=0, Pending=0, ReqReady=0.
- Latency: a transfer accepted at edge N gives RegWrite high during cycle N..N+1, and the register file writes at edge N+1. Data is readable from the file's asynchronous ports after edge N+1.
- Throughput: 1 write/cycle. With all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.
- Pending[r] falls at the acceptance edge, one edge before the file write. Issue logic must add one cycle of bypass or stall.
- Reset asserted mid-operation: an accepted but not yet written transfer is discarded (RegWrite forced 0 immediately). All reservations are lost and Ptr returns to 0.
- Deassertion of Reset is synchronised by the system. The first grant can occur on the first edge after deassertion.

## Structure
- Shared package: REG_ADDR_W=5, REG_W=32, NUM_REGS=32, ZERO_REG=5'd0.
- One sub-module, rr_picker: combinational; inputs ReqValid and Ptr; outputs a one-hot grant and an encoded winner index. The top level holds Ptr, the output registers and the scoreboard.

## Test plan
- Reset: assert Reset mid-stream with RegWrite=1 and Pending=32'h0000_0F00 -> all outputs 0 immediately, with ReqReady=0 during reset.
- Single requester: ReqValid=4'b0010, addr 9, data 32'hDEAD_BEEF -> ReqReady=4'b0010. Next cycle RegWrite=1, WriteRegister=9, WriteData=32'hDEADBEEF. Ptr becomes 2.
- Fairness: all four valid for 8 cycles starting at Ptr=0 -> grant order 0,1,2,3,0,1,2,3, with RegWrite high every cycle.
- Zero register: requester 3 writes addr 0, data 32'h1234 -> ReqReady[3]=1, RegWrite stays 0, and Ptr advances to 0.
- Scoreboard: Reserve addr 7 -> Pending=32'h80. A later transfer to 7 clears bit 7 at the acceptance edge. A simultaneous Reserve 7 plus transfer to 7 leaves bit 7 set. Reserve addr 0 leaves Pending=0.
- Stall hold: requester 2 valid with data changing before its grant is a protocol violation. The bench asserts stability and checks that the written data equals the held value.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file geometry for the writeback arbiter and its picker.
package regfile_write_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    return NUM_REGS'(1) << addr;
  endfunction
endpackage

// File: rtl/regfile_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, wrapping.
module rr_picker #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [PTR_W-1:0] winner_o,
  output logic             any_o
);

  int idx;

  // Walk the search order backwards so the earliest candidate is the last to overwrite.
  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = (int'(ptr_i) + off) % NREQ;
      if (req_valid_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        winner_o     = PTR_W'(idx);
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a pending-write scoreboard.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NREQ-1:0]            ReqValid,
  input  logic [REG_ADDR_W*NREQ-1:0] ReqAddr,
  input  logic [REG_W*NREQ-1:0]      ReqData,
  output logic [NREQ-1:0]            ReqReady,
  input  logic                       Reserve,
  input  logic [REG_ADDR_W-1:0]      ReserveAddr,
  output logic                       RegWrite,
  output logic [REG_ADDR_W-1:0]      WriteRegister,
  output logic [REG_W-1:0]           WriteData,
  output logic [NUM_REGS-1:0]        Pending
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [REG_W-1:0]      wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  logic [NREQ-1:0]       grant;
  logic [PTR_W-1:0]      winner;
  logic                  any_valid;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [REG_W-1:0]      sel_data;

  rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
    .req_valid_i (ReqValid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .winner_o    (winner),
    .any_o       (any_valid)
  );

  assign ReqReady = Reset ? '0 : grant;
  assign xfer     = any_valid & ~Reset;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == PTR_W'(i)) begin
        sel_addr = ReqAddr[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = ReqData[i*REG_W +: REG_W];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    reg_write_d = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    pending_d   = pending_q;
    if (xfer) begin
      ptr_d     = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
      pending_d = pending_d & ~reg_onehot(sel_addr);
      // Writes to $zero are consumed but never reach the file.
      if (sel_addr != ZERO_REG) begin
        reg_write_d = 1'b1;
        wr_reg_d    = sel_addr;
        wr_data_d   = sel_data;
      end
    end
    // Reservation applied after the clear so a same-edge set wins.
    if (Reserve && ReserveAddr != ZERO_REG) begin
      pending_d = pending_d | reg_onehot(ReserveAddr);
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q       <= '0;
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      pending_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      pending_q   <= pending_d;
    end
  end

  assign RegWrite      = reg_write_q;
  assign WriteRegister = wr_reg_q;
  assign WriteData     = wr_data_q;
  assign Pending       = pending_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected file writes, a negedge monitor pops and compares.
module tb_regfile_write_arbiter;
  localparam int NREQ = 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [NREQ-1:0]  ReqValid;
  logic [5*NREQ-1:0]  ReqAddr;
  logic [32*NREQ-1:0] ReqData;
  logic [NREQ-1:0]  ReqReady;
  logic             Reserve;
  logic [4:0]       ReserveAddr;
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [31:0]      WriteData;
  logic [31:0]      Pending;

  int tests = 0;
  int fails = 0;

  logic [4:0]  req_addr [NREQ];
  logic [31:0] req_data [NREQ];
  logic [36:0] exp_q [$];
  bit          no_push = 1'b0;

  regfile_write_arbiter #(.NREQ(NREQ)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ReqValid      (ReqValid),
    .ReqAddr       (ReqAddr),
    .ReqData       (ReqData),
    .ReqReady      (ReqReady),
    .Reserve       (Reserve),
    .ReserveAddr   (ReserveAddr),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Pending       (Pending)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every file write must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (RegWrite === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: got reg %0d data %h expected no write", WriteRegister, WriteData);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({WriteRegister, WriteData} !== e) begin
          fails++;
          $display("FAIL write_data: got reg %0d data %h expected reg %0d data %h",
                   WriteRegister, WriteData, e[36:32], e[31:0]);
        end
      end
    end
  end

  // Requester 2 protocol check: data held stable while waiting for its grant.
  logic        r2_wait = 1'b0;
  logic [31:0] r2_prev = '0;
  always @(negedge Clk) begin
    if (r2_wait && ReqValid[2]) begin
      tests++;
      if (ReqData[95:64] !== r2_prev) begin
        fails++;
        $display("FAIL r2_stable: got %h expected %h", ReqData[95:64], r2_prev);
      end
    end
    r2_wait = ReqValid[2] && !ReqReady[2];
    r2_prev = ReqData[95:64];
  end

  task automatic drive(input logic [3:0] v, input logic rsv, input logic [4:0] ra);
    ReqValid    = v;
    Reserve     = rsv;
    ReserveAddr = ra;
    for (int i = 0; i < NREQ; i++) begin
      ReqAddr[i*5 +: 5]   = req_addr[i];
      ReqData[i*32 +: 32] = req_data[i];
    end
  endtask

  // One cycle: drive, check grant at negedge, record expected write, step past the edge.
  task automatic cyc(input string name, input logic [3:0] v, input logic rsv,
                     input logic [4:0] ra, input logic [3:0] exp_rdy);
    drive(v, rsv, ra);
    @(negedge Clk);
    chk(name, 32'(ReqReady), 32'(exp_rdy));
    for (int g = 0; g < NREQ; g++)
      if (exp_rdy[g] && req_addr[g] != 5'd0 && !no_push)
        exp_q.push_back({req_addr[g], req_data[g]});
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = 5'(i + 1);
      req_data[i] = 32'hA0 + i;
    end
    drive(4'b1111, 1'b0, 5'd0);
    @(negedge Clk);
    chk("rst_ready", 32'(ReqReady), 32'h0);
    chk("rst_regwrite", 32'(RegWrite), 32'h0);
    chk("rst_wreg", 32'(WriteRegister), 32'h0);
    chk("rst_wdata", WriteData, 32'h0);
    chk("rst_pending", Pending, 32'h0);
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Single requester.
    req_addr[1] = 5'd9; req_data[1] = 32'hDEAD_BEEF;
    cyc("single_grant", 4'b0010, 1'b0, 5'd0, 4'b0010);
    chk("single_regwrite", 32'(RegWrite), 32'h1);
    chk("single_wreg", 32'(WriteRegister), 32'd9);
    chk("single_wdata", WriteData, 32'hDEAD_BEEF);

    // Zero register from requester 3 (Ptr=2 -> search 2,3 -> grant 3, Ptr -> 0).
    req_addr[3] = 5'd0; req_data[3] = 32'h1234;
    cyc("zero_grant", 4'b1000, 1'b0, 5'd0, 4'b1000);
    chk("zero_regwrite", 32'(RegWrite), 32'h0);
    chk("zero_wreg_hold", 32'(WriteRegister), 32'd9);
    chk("zero_wdata_hold", WriteData, 32'hDEAD_BEEF);

    // Fairness: all valid from Ptr=0.
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = 5'(i + 1);
      req_data[i] = 32'hA0 + i;
    end
    for (int k = 0; k < 8; k++)
      cyc($sformatf("fair_%0d", k), 4'b1111, 1'b0, 5'd0, 4'(1 << (k % 4)));
    chk("fair_last_regwrite", 32'(RegWrite), 32'h1);

    // Scoreboard (Ptr=0).
    cyc("sb_rsv7", 4'b0000, 1'b1, 5'd7, 4'b0000);
    chk("sb_set7", Pending, 32'h0000_0080);
    req_addr[1] = 5'd7; req_data[1] = 32'h0000_0707;
    cyc("sb_clr_grant", 4'b0010, 1'b0, 5'd0, 4'b0010);
    chk("sb_clear7", Pending, 32'h0);
    req_addr[2] = 5'd7; req_data[2] = 32'h0000_0772;
    cyc("sb_both_grant", 4'b0100, 1'b1, 5'd7, 4'b0100);
    chk("sb_set_wins", Pending, 32'h0000_0080);
    cyc("sb_rsv0", 4'b0000, 1'b1, 5'd0, 4'b0000);
    chk("sb_rsv0_ignored", Pending, 32'h0000_0080);
    req_addr[3] = 5'd7; req_data[3] = 32'h0000_0773;
    cyc("sb_clr2_grant", 4'b1000, 1'b0, 5'd0, 4'b1000);
    chk("sb_clear7_again", Pending, 32'h0);

    // Stall hold (Ptr=0): requester 2 waits one cycle behind requester 0.
    req_addr[0] = 5'd5;  req_data[0] = 32'h55;
    req_addr[2] = 5'd12; req_data[2] = 32'hCAFE;
    cyc("stall_first", 4'b0101, 1'b0, 5'd0, 4'b0001);
    cyc("stall_second", 4'b0100, 1'b0, 5'd0, 4'b0100);
    chk("stall_wdata", WriteData, 32'hCAFE);

    // Reset mid-stream (Ptr=3): build Pending=0F00 with a write in flight.
    cyc("rs_rsv8", 4'b0000, 1'b1, 5'd8, 4'b0000);
    cyc("rs_rsv9", 4'b0000, 1'b1, 5'd9, 4'b0000);
    cyc("rs_rsv10", 4'b0000, 1'b1, 5'd10, 4'b0000);
    req_addr[1] = 5'd3; req_data[1] = 32'h77;
    no_push = 1'b1;
    cyc("rs_grant", 4'b0010, 1'b1, 5'd11, 4'b0010);
    no_push = 1'b0;
    chk("rs_pre_regwrite", 32'(RegWrite), 32'h1);
    chk("rs_pre_pending", Pending, 32'h0000_0F00);
    Reset = 1'b1;
    drive(4'b1111, 1'b0, 5'd0);
    #1;
    chk("rs_regwrite", 32'(RegWrite), 32'h0);
    chk("rs_pending", Pending, 32'h0);
    chk("rs_wreg", 32'(WriteRegister), 32'h0);
    chk("rs_wdata", WriteData, 32'h0);
    @(negedge Clk);
    chk("rs_ready", 32'(ReqReady), 32'h0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    cyc("rs_first_grant", 4'b1111, 1'b0, 5'd0, 4'b0001);

    drive(4'b0000, 1'b0, 5'd0);
    repeat (3) @(posedge Clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
